// File: rtl/poca_bridge_pkg.sv
// poca_bridge_pkg: shared ids, states and sizes for the poca peripheral bridge
package poca_bridge_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;
  localparam int RESULT_W = 256;
  localparam int TRNG_W = 128;
  localparam int TRNG_WORDS = 4;
  localparam int ECC_WORDS = 8;
  localparam int HASH_WORDS = 8;
  localparam int TIMEOUT_CYC = 4096;
  localparam int CNT_W = 4;
  localparam int TO_W = $clog2(TIMEOUT_CYC);
  typedef enum logic [1:0] {TRNG_ID = 2'd0, ECC_ID = 2'd1, HASH_ID = 2'd2, NONE_ID = 2'd3} core_id_t;
  typedef enum logic [2:0] {IDLE, WAIT_ACK, WAIT_DONE, STREAM, COMPLETE} state_t;
  function automatic logic [CNT_W-1:0] words_for(core_id_t id);
    return id == TRNG_ID ? CNT_W'(TRNG_WORDS) : id == ECC_ID ? CNT_W'(ECC_WORDS) : CNT_W'(HASH_WORDS);
  endfunction
endpackage

// File: rtl/poca_periph_bridge_if.sv
// poca_periph_bridge_if: poca_master side request/stream bus of the bridge
interface poca_periph_bridge_if;
  import poca_bridge_pkg::*;
  logic [ADDR_W-1:0] addr_in;
  logic is_write;
  logic write_complete;
  logic [DATA_W-1:0] data_out;
  logic data_input_ready;
  logic input_data_transfer_complete;
  logic busy;
  logic err;
  modport master(output addr_in, is_write,
                 input write_complete, data_out, data_input_ready, input_data_transfer_complete, busy, err);
  modport slave(input addr_in, is_write,
                output write_complete, data_out, data_input_ready, input_data_transfer_complete, busy, err);
endinterface

// File: rtl/poca_word_serializer.sv
// poca_word_serializer: streams a wide result as DATA_W words, LS word first
module poca_word_serializer import poca_bridge_pkg::*; (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic [CNT_W-1:0] nwords,
  input  logic [RESULT_W-1:0] din,
  output logic [DATA_W-1:0] data_out,
  output logic ready,
  output logic complete,
  output logic last
);
  logic [RESULT_W-1:0] sr;
  logic [CNT_W-1:0] cnt;
  logic cmp;
  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
      cnt <= '0;
      cmp <= 1'b0;
    end else begin
      sr <= load ? din : sr >> DATA_W;
      cnt <= load ? nwords : ready ? cnt - 1'b1 : cnt;
      cmp <= last;
    end
  end
  assign ready = cnt != '0;
  assign last = cnt == CNT_W'(1);
  assign data_out = ready ? sr[DATA_W-1:0] : '0;
  assign complete = cmp;
endmodule

// File: rtl/poca_periph_bridge.sv
// poca_periph_bridge: start/ack handshake to TRNG/ECC/Hash cores and word-streaming of their results
module poca_periph_bridge import poca_bridge_pkg::*; (
  input  logic clk,
  input  logic rst,
  poca_periph_bridge_if.slave bus,
  output logic [2:0] periph_start,
  input  logic [2:0] periph_ack,
  input  logic [2:0] periph_done,
  input  logic [TRNG_W-1:0] trng_result,
  input  logic [RESULT_W-1:0] ecc_result,
  input  logic [RESULT_W-1:0] hash_result
);
  state_t state, state_n;
  core_id_t sel, sel_n;
  logic [TO_W-1:0] tcnt;
  logic [2:0] sel_oh;
  logic [RESULT_W-1:0] res;
  logic ack, done, to, load, last, wc, err_q, err_n;
  assign sel_oh = 3'b001 << sel;
  assign ack = |(periph_ack & sel_oh);
  assign done = |(periph_done & sel_oh);
  assign to = tcnt == TO_W'(TIMEOUT_CYC - 1);
  assign res = sel == TRNG_ID ? RESULT_W'(trng_result) : sel == ECC_ID ? ecc_result : hash_result;
  always_comb begin
    state_n = state;
    sel_n = sel;
    load = 1'b0;
    err_n = 1'b0;
    case (state)
      IDLE: if (bus.is_write) begin
        if (bus.addr_in[1:0] == 2'd3) err_n = 1'b1;
        else begin
          sel_n = core_id_t'(bus.addr_in[1:0]);
          state_n = WAIT_ACK;
        end
      end
      WAIT_ACK: if (ack) begin
        load = done;
        state_n = done ? STREAM : WAIT_DONE;
      end else if (to) begin
        err_n = 1'b1;
        state_n = IDLE;
      end
      WAIT_DONE: if (done) begin
        load = 1'b1;
        state_n = STREAM;
      end else if (to) begin
        err_n = 1'b1;
        state_n = IDLE;
      end
      STREAM: state_n = last ? COMPLETE : STREAM;
      default: state_n = IDLE;
    endcase
  end
  // Timeout counter restarts on every state change, so each waiting state gets a full window
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sel <= TRNG_ID;
      tcnt <= '0;
      wc <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      sel <= sel_n;
      tcnt <= state_n != state ? '0 : tcnt + 1'b1;
      wc <= state == WAIT_ACK && ack;
      err_q <= err_n;
    end
  end
  poca_word_serializer u_ser (
    .clk(clk),
    .rst(rst),
    .load(load),
    .nwords(words_for(sel)),
    .din(res),
    .data_out(bus.data_out),
    .ready(bus.data_input_ready),
    .complete(bus.input_data_transfer_complete),
    .last(last)
  );
  assign periph_start = state == WAIT_ACK ? sel_oh : 3'b000;
  assign bus.write_complete = wc;
  assign bus.busy = state != IDLE;
  assign bus.err = err_q;
endmodule

// File: tb/tb_poca_periph_bridge.sv
// tb_poca_periph_bridge: scoreboard bench for the poca peripheral bridge
module tb_poca_periph_bridge;
  import poca_bridge_pkg::*;
  typedef enum logic [1:0] {K_WC, K_ERR, K_WORD, K_CMP} kind_t;
  typedef struct packed {kind_t k; logic [31:0] d;} exp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [2:0] periph_start, periph_ack = '0, periph_done = '0;
  logic [127:0] trng_result = '0;
  logic [255:0] ecc_result = '0, hash_result = '0;
  int compared = 0, mismatched = 0;
  exp_t q[$];
  poca_periph_bridge_if bus();
  poca_periph_bridge dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .periph_start(periph_start),
    .periph_ack(periph_ack),
    .periph_done(periph_done),
    .trng_result(trng_result),
    .ecc_result(ecc_result),
    .hash_result(hash_result)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic pop_cmp(input kind_t k, input logic [31:0] d);
    exp_t e;
    compared++;
    if (q.size() == 0) begin
      mismatched++;
      $display("FAIL unexpected_event: got kind %0d data %h expected nothing", k, d);
    end else begin
      e = q.pop_front();
      if (e.k != k || e.d !== d) begin
        mismatched++;
        $display("FAIL event: got kind %0d data %h expected kind %0d data %h", k, d, e.k, e.d);
      end
    end
  endtask
  always @(negedge clk) begin
    if (bus.write_complete) pop_cmp(K_WC, 32'h0);
    if (bus.err) pop_cmp(K_ERR, 32'h0);
    if (bus.data_input_ready) pop_cmp(K_WORD, bus.data_out);
    if (bus.input_data_transfer_complete) pop_cmp(K_CMP, 32'h0);
    if (!bus.data_input_ready) check("idle_data_zero", 64'(bus.data_out), 64'h0);
  end
  task automatic expect_ev(input kind_t k, input logic [31:0] d);
    q.push_back('{k, d});
  endtask
  task automatic expect_stream(input logic [255:0] r, input int n);
    expect_ev(K_WC, 32'h0);
    for (int i = 0; i < n; i++) expect_ev(K_WORD, r[i*32 +: 32]);
    expect_ev(K_CMP, 32'h0);
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic req(input logic [7:0] a);
    bus.is_write = 1'b1;
    bus.addr_in = a;
    tick(1);
    bus.is_write = 1'b0;
  endtask
  task automatic core(input logic [2:0] a, input logic [2:0] d);
    periph_ack = a;
    periph_done = d;
    tick(1);
    periph_ack = '0;
    periph_done = '0;
  endtask
  task automatic wait_cmp(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.input_data_transfer_complete && n < 200);
    check(name, 64'(bus.input_data_transfer_complete), 64'h1);
  endtask
  function automatic logic [63:0] outs();
    return {periph_start, bus.write_complete, bus.data_out, bus.data_input_ready,
            bus.input_data_transfer_complete, bus.busy, bus.err};
  endfunction
  initial begin
    int n;
    bus.is_write = 1'b0;
    bus.addr_in = '0;
    tick(3);
    check("reset_outputs", outs(), 64'h0);
    rst = 1'b0;
    tick(1);
    // TRNG: ack three cycles into start, done ten cycles later
    trng_result = 128'h00000001_00000015_00000000_00000015;
    expect_stream(256'(trng_result), 4);
    req(8'h00);
    check("trng_start", 64'(periph_start), 64'h1);
    check("trng_busy", 64'(bus.busy), 64'h1);
    tick(2);
    core(3'b001, 3'b000);
    check("trng_start_drop", 64'(periph_start), 64'h0);
    tick(9);
    core(3'b000, 3'b001);
    wait_cmp("trng_complete");
    tick(1);
    // Hash, issued back-to-back with the TRNG completion
    for (int i = 0; i < 8; i++) hash_result[i*32 +: 32] = 32'(i + 1);
    expect_stream(hash_result, 8);
    req(8'h02);
    check("hash_start", 64'(periph_start), 64'h4);
    core(3'b100, 3'b000);
    tick(1);
    core(3'b000, 3'b100);
    wait_cmp("hash_complete");
    check("hash_busy_at_complete", 64'(bus.busy), 64'h1);
    tick(1);
    check("hash_busy_fall", 64'(bus.busy), 64'h0);
    // Unmapped address
    expect_ev(K_ERR, 32'h0);
    req(8'h03);
    check("unmapped_start", 64'(periph_start), 64'h0);
    check("unmapped_busy", 64'(bus.busy), 64'h0);
    tick(1);
    // Timeout on ECC: ack never comes
    expect_ev(K_ERR, 32'h0);
    req(8'h01);
    n = 0;
    while (periph_start == 3'b010 && n < 5000) begin
      n++;
      tick(1);
    end
    check("timeout_start_cycles", 64'(n), 64'(TIMEOUT_CYC));
    check("timeout_idle", 64'(bus.busy), 64'h0);
    tick(1);
    // ECC with ack and done together, stray TRNG done mid-stream
    for (int i = 0; i < 8; i++) ecc_result[i*32 +: 32] = 32'hECC0_0000 + 32'(i);
    expect_stream(ecc_result, 8);
    req(8'h01);
    tick(1);
    core(3'b010, 3'b010);
    check("ecc_start_drop", 64'(periph_start), 64'h0);
    check("ecc_first_word", 64'(bus.data_out), 64'hECC0_0000);
    tick(2);
    core(3'b000, 3'b001);
    wait_cmp("ecc_complete");
    tick(1);
    // Reset on the third stream word, then a late done is ignored
    trng_result = 128'hAAAA0004_BBBB0003_CCCC0002_DDDD0001;
    expect_ev(K_WC, 32'h0);
    expect_ev(K_WORD, 32'hDDDD0001);
    expect_ev(K_WORD, 32'hCCCC0002);
    expect_ev(K_WORD, 32'hBBBB0003);
    req(8'h00);
    core(3'b001, 3'b000);
    tick(1);
    core(3'b000, 3'b001);
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("midstream_reset_outputs", outs(), 64'h0);
    core(3'b000, 3'b001);
    tick(2);
    check("late_done_ignored", outs(), 64'h0);
    // Fresh TRNG after reset
    trng_result = 128'h12345678_9ABCDEF0_0F0F0F0F_F0F0F0F0;
    expect_stream(256'(trng_result), 4);
    req(8'h00);
    core(3'b001, 3'b000);
    tick(3);
    core(3'b000, 3'b001);
    wait_cmp("fresh_trng_complete");
    tick(2);
    check("scoreboard_drained", 64'(q.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
